// File: rtl/alu_sequencer.sv
// Initiator side of the ALU interface: one decoded op per handshake, drives the external
// combinational ALU, registers its result, and runs MULTU as iterated shift-add through the ADD path.
module alu_sequencer #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic        res_zero,
  output logic        illegal
);

  localparam int              CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  typedef struct packed {
    logic       mul;
    logic       ill;
    logic [3:0] ctrl;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
    dec_t d;
    d = '{mul: 1'b0, ill: 1'b0, ctrl: CTRL_BAD};
    case (op)
      2'b00: d.ctrl = CTRL_ADD;
      2'b01: d.ctrl = CTRL_SUB;
      2'b10: begin
        case (fn)
          6'b100000: d.ctrl = CTRL_ADD;
          6'b100010: d.ctrl = CTRL_SUB;
          6'b100100: d.ctrl = CTRL_AND;
          6'b100101: d.ctrl = CTRL_OR;
          6'b100111: d.ctrl = CTRL_NOR;
          6'b101010: d.ctrl = CTRL_SLT;
          6'b011001: begin d.mul = 1'b1; d.ctrl = CTRL_ADD; end
          default:   d.ill = 1'b1;
        endcase
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  state_t           state, state_nxt;
  dec_t             dec;
  logic [31:0]      mcand, mplr;
  logic [CNT_W-1:0] cnt;
  logic             ill_q;
  logic             carry;
  logic [31:0]      acc_nxt, mplr_nxt;

  assign dec = decode(alu_op, funct);

  // One shift-add step: alu_data1 holds the running high word, the ALU adds the partial product.
  always_comb begin
    carry    = (alu_result < alu_data1);
    acc_nxt  = {carry, alu_result[31:1]};
    mplr_nxt = {alu_result[0], mplr[31:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = dec.mul ? MUL : EXEC;
      EXEC:    state_nxt = DONE;
      MUL:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    res_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_ctrl  <= CTRL_BAD;
      res_lo    <= '0;
      res_hi    <= '0;
      res_zero  <= 1'b0;
      illegal   <= 1'b0;
      ill_q     <= 1'b0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ill_q <= dec.ill;
            mcand <= op_a;
            mplr  <= op_b;
            cnt   <= '0;
            if (dec.mul) begin
              alu_data1 <= '0;
              alu_data2 <= op_b[0] ? op_a : '0;
              alu_ctrl  <= CTRL_ADD;
            end else begin
              alu_data1 <= op_a;
              alu_data2 <= op_b;
              alu_ctrl  <= dec.ctrl;
            end
          end
        end
        EXEC: begin
          // Unsupported ops report a clean zero regardless of what the ALU returns.
          res_lo   <= ill_q ? '0 : alu_result;
          res_hi   <= '0;
          res_zero <= ill_q ? 1'b1 : alu_zero;
          illegal  <= ill_q;
        end
        MUL: begin
          alu_data1 <= acc_nxt;
          alu_data2 <= mplr_nxt[0] ? mcand : '0;
          mplr      <= mplr_nxt;
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            res_hi   <= acc_nxt;
            res_lo   <= mplr_nxt;
            res_zero <= ({acc_nxt, mplr_nxt} == 64'd0);
            illegal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, runs a directed vector table, multi-cycle
// corner sequences and randomized ops checked against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_data1, alu_data2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo, res_hi;
  logic        res_zero;
  logic        illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LAT_LIMIT = 100;

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi), .res_zero(res_zero), .illegal(illegal)
  );

  // External combinational ALU (SLT is an unsigned compare)
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b1100: alu_result = ~(alu_data1 | alu_data2);
      4'b0111: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result of the op computed directly from its arithmetic meaning.
  task automatic ref_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] lo, output logic [31:0] hi,
                        output logic z, output logic ill, output int lat);
    logic [63:0] prod;
    lo = 32'd0; hi = 32'd0; ill = 1'b0; lat = 2;
    case (op)
      2'd0: lo = a + b;
      2'd1: lo = a - b;
      2'd2: begin
        case (fn)
          6'h20: lo = a + b;
          6'h22: lo = a - b;
          6'h24: lo = a & b;
          6'h25: lo = a | b;
          6'h27: lo = ~(a | b);
          6'h2A: lo = (a < b) ? 32'd1 : 32'd0;
          6'h19: begin
            prod = {32'd0, a} * {32'd0, b};
            hi = prod[63:32];
            lo = prod[31:0];
            lat = 33;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    z = ({hi, lo} == 64'd0);
  endtask

  task automatic wait_result(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    alu_op = op; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    wait_result(lat);
  endtask

  task automatic release_op(input string name);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, " rel_valid"}, res_valid, 0);
    chk({name, " rel_ready"}, in_ready, 1);
  endtask

  task automatic check_result(input string name, input logic [31:0] lo, input logic [31:0] hi,
                              input logic z, input logic ill, input int lat, input int got_lat);
    chk({name, " lat"}, got_lat, lat);
    chk({name, " lo"}, res_lo, lo);
    chk({name, " hi"}, res_hi, hi);
    chk({name, " zero"}, res_zero, z);
    chk({name, " illegal"}, illegal, ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] e_lo, e_hi;
    logic e_z, e_ill;
    int e_lat;
    logic [5:0] functs[7];
    logic [1:0] r_op;
    logic [5:0] r_fn;
    logic [31:0] r_a, r_b, held_lo;

    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h19};

    vecs[0]  = '{2'd2, 6'h20, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1'b0, 2};
    vecs[1]  = '{2'd1, 6'h00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 2};
    vecs[2]  = '{2'd2, 6'h24, 32'hF0F0_0000, 32'h0FF0_0001, 32'h00F0_0000, 32'd0, 1'b0, 1'b0, 2};
    vecs[3]  = '{2'd2, 6'h25, 32'hF0F0_0000, 32'h0FF0_0001, 32'hFFF0_0001, 32'd0, 1'b0, 1'b0, 2};
    vecs[4]  = '{2'd2, 6'h27, 32'hF0F0_0000, 32'h0FF0_0001, 32'h000F_FFFE, 32'd0, 1'b0, 1'b0, 2};
    vecs[5]  = '{2'd2, 6'h2A, 32'hF0F0_0000, 32'h0FF0_0001, 32'd0, 32'd0, 1'b1, 1'b0, 2};
    vecs[6]  = '{2'd2, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33};
    vecs[7]  = '{2'd2, 6'h19, 32'd0, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0, 33};
    vecs[8]  = '{2'd2, 6'h00, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 1'b1, 2};
    vecs[9]  = '{2'd3, 6'h20, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 1'b1, 2};
    vecs[10] = '{2'd0, 6'h00, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0, 2};
    vecs[11] = '{2'd2, 6'h2A, 32'd1, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0, 2};
    vecs[12] = '{2'd2, 6'h22, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 2};
    vecs[13] = '{2'd2, 6'h19, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0, 1'b0, 33};
    vecs[14] = '{2'd2, 6'h19, 32'd3, 32'h8000_0001, 32'h8000_0003, 32'd1, 1'b0, 1'b0, 33};

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    alu_op = 2'd0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_lo", res_lo, 0);
    chk("rst res_hi", res_hi, 0);
    chk("rst res_zero", res_zero, 0);
    chk("rst illegal", illegal, 0);
    chk("rst alu_ctrl", alu_ctrl, 4'b1111);
    chk("rst alu_data1", alu_data1, 0);
    chk("rst alu_data2", alu_data2, 0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, lat);
      check_result($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].z, vecs[i].ill,
                   vecs[i].lat, lat);
      release_op($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with a competing request that must wait for IDLE
    do_op(2'd2, 6'h20, 32'd20, 32'd22, lat);
    chk("bp lat", lat, 2);
    alu_op = 2'd2; funct = 6'h22; op_a = 32'd50; op_b = 32'd7; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d valid", k), res_valid, 1);
      chk($sformatf("bp%0d in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d lo", k), res_lo, 32'd42);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp rel_valid", res_valid, 0);
    chk("bp rel_ready", in_ready, 1);
    @(posedge clk);
    wait_result(lat);
    check_result("bp next", 32'd43, 32'd0, 1'b0, 1'b0, 2, lat);
    release_op("bp next");

    // Reset during the 10th MUL cycle discards the product
    @(negedge clk);
    alu_op = 2'd2; funct = 6'h19; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst in_ready", in_ready, 1);
    chk("mrst res_valid", res_valid, 0);
    chk("mrst res_hi", res_hi, 0);
    chk("mrst alu_ctrl", alu_ctrl, 4'b1111);
    repeat (40) @(negedge clk);
    chk("mrst no_result", res_valid, 0);
    do_op(2'd0, 6'd0, 32'd1, 32'd1, lat);
    check_result("mrst add", 32'd2, 32'd0, 1'b0, 1'b0, 2, lat);
    release_op("mrst add");

    // Randomized ops against the reference model, with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_fn = ($urandom_range(0, 7) == 7) ? 6'($urandom) : functs[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) begin
        r_a = $urandom_range(0, 15);
        r_b = $urandom_range(0, 15);
      end else begin
        r_a = $urandom;
        r_b = $urandom;
      end
      ref_op(r_op, r_fn, r_a, r_b, e_lo, e_hi, e_z, e_ill, e_lat);
      do_op(r_op, r_fn, r_a, r_b, lat);
      check_result($sformatf("rnd%0d", i), e_lo, e_hi, e_z, e_ill, e_lat, lat);
      held_lo = e_lo;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("rnd%0d hold", i), res_lo, held_lo);
      release_op($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
